// File: rtl/serial_tc_pkg.sv
// Shared definitions for the bit-serial two's-complement sequencer and its cell.
package serial_tc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_tc_cell.sv
// Mealy two's-complement cell: passes bits through until the first 1 has gone by,
// then inverts every later bit.
module serial_tc_cell (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    input  logic x_in,
    output logic y_out
);

    logic seen_q;
    logic seen_d;

    always_comb begin
        seen_d = seen_q;
        if (clr) begin
            seen_d = 1'b0;
        end else if (en) begin
            seen_d = seen_q | x_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign y_out = seen_q ? ~x_in : x_in;

endmodule

// File: rtl/serial_twos_comp_ctrl.sv
// Sequencer: accepts a parallel word, streams it LSB-first through serial_tc_cell,
// reassembles the result and pulses done for one cycle.
module serial_twos_comp_ctrl
    import serial_tc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cell_clr;
    logic             cell_en;
    logic             cell_y;

    serial_tc_cell u_cell (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (cell_clr),
        .en    (cell_en),
        .x_in  (sr_q[0]),
        .y_out (cell_y)
    );

    // Handshake: start is a level request sampled only in IDLE; while busy it is
    // ignored (not queued). done is a single-cycle pulse in DONE; dout/overflow
    // change only on the edge entering DONE and hold until the next one.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        res_d    = res_q;
        op_d     = op_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        cell_clr = 1'b0;
        cell_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d     = din;
                    op_d     = din;
                    res_d    = '0;
                    cnt_d    = '0;
                    cell_clr = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cell_en = 1'b1;
                res_d   = {cell_y, res_q[WIDTH-1:1]};
                sr_d    = sr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    dout_d  = {cell_y, res_q[WIDTH-1:1]};
                    ovf_d   = (op_q == MOST_NEG);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            res_q   <= '0;
            op_q    <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            res_q   <= res_d;
            op_q    <= op_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dout      = dout_q;
    assign overflow  = ovf_q;
    assign state_dbg = state_q;

endmodule
